// File: rtl/mul_share_pkg.sv
// ============================================================================
// mul_share_pkg : shared constants, ID-width helper and stage-1 record type
//                 for the shared multiplier arbiter.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mul_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int M_DEF    = 6;
  localparam int N_DEF    = 3;

  // Minimum ID width able to index n requesters (never narrower than 1 bit)
  function automatic int idw_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDW_DEF = idw_for(NREQ_DEF);

  typedef struct packed {
    logic               valid;
    logic [IDW_DEF-1:0] id;
    logic [M_DEF-1:0]   a;
    logic [N_DEF-1:0]   b;
  } stage1_t;

endpackage

`default_nettype wire

// File: rtl/mul_share_arb_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin arbiter; search starts one past the last winner.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = idw_for(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  logic [IDW-1:0] last;

  assign any = |req;

  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_onehot
    assign grant_onehot[i] = any && (grant_idx == IDW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDW'(NREQ - 1);
    end else if (en && any) begin
      last <= grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_share_arb.sv
// ============================================================================
// mul_share_arb : NREQ requesters share one 2-stage unsigned multiplier;
//                 tagged results leave on a single valid/ready port.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int M    = M_DEF,
  parameter int N    = N_DEF,
  parameter int IDW  = idw_for(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*M-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [M+N-1:0]    rsp_p,
  output logic              busy,
  output logic [15:0]       done_cnt
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [M-1:0]   a;
    logic [N-1:0]   b;
  } s1_t;

  s1_t             s1;
  logic            v2;
  logic [IDW-1:0]  id2;
  logic [M+N-1:0]  p2;

  logic            advance;
  logic            any;
  logic            grant;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  win;

  // A held response freezes the whole pipeline, including the arbiter pointer
  assign advance = !(v2 && !rsp_ready);
  assign grant   = any && advance && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req_valid),
    .en           (advance),
    .grant_onehot (gnt_oh),
    .grant_idx    (win),
    .any          (any)
  );

  assign req_ready = grant ? gnt_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      v2       <= 1'b0;
      id2      <= '0;
      p2       <= '0;
      done_cnt <= '0;
    end else begin
      if (advance) begin
        s1.valid <= grant;
        if (grant) begin
          s1.id <= win;
          s1.a  <= req_a[int'(win)*M +: M];
          s1.b  <= req_b[int'(win)*N +: N];
        end
        v2  <= s1.valid;
        id2 <= s1.id;
        p2  <= (M+N)'(s1.a) * (M+N)'(s1.b);
      end
      if (v2 && rsp_ready) begin
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

  assign rsp_valid = v2;
  assign rsp_id    = id2;
  assign rsp_p     = p2;
  assign busy      = s1.valid | v2;

endmodule

`default_nettype wire
